// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
//
// Performs a WORDS*WIDTH-bit add or subtract by running one shared WIDTH-bit
// ripple adder over the operand one word slice per cycle, least significant
// word first. The carry between slices is held in a register. Requests and
// results use valid/ready handshakes.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request can be accepted (IDLE only)
//   op_sub     0: a+b+cin, 1: a-b-cin (cin is borrow-in)
//   cin        carry-in / borrow-in
//   a, b       WORDS*WIDTH-bit operands, word 0 holds the LSBs
//   out_valid  result held and valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        WORDS*WIDTH-bit result
//   cout       carry out of the final word (sub: 1 = no borrow)
//   overflow   signed overflow of the full-width result
//   busy       operation in RUN or waiting in DONE
// -----------------------------------------------------------------------------
module multiword_add_sequencer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     op_sub,
   input  logic                     cin,
   input  logic [WORDS*WIDTH-1:0]   a,
   input  logic [WORDS*WIDTH-1:0]   b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORDS*WIDTH-1:0]   sum,
   output logic                     cout,
   output logic                     overflow,
   output logic                     busy
);

   localparam int TOTAL = WORDS * WIDTH;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state, state_next;
   logic [IDX_W-1:0]   idx;
   logic               carry_reg;
   logic [TOTAL-1:0]   a_reg, b_reg;
   logic [TOTAL-1:0]   sum_reg;
   logic               cout_reg, ovf_reg;

   logic               accept;
   logic               last_slice;
   logic [WIDTH-1:0]   a_word, b_word, add_sum;
   logic [WIDTH:0]     carry_chain;
   logic               add_cout;
   logic               msb_carry_in;

   assign accept     = (state == IDLE) && in_valid;
   assign last_slice = (idx == LAST_IDX);

   // ---------------------------------------------------------------------------
   // Word-slice selection for the shared adder
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (idx == IDX_W'(w)) begin
            a_word = a_reg[w*WIDTH +: WIDTH];
            b_word = b_reg[w*WIDTH +: WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Shared WIDTH-bit ripple adder (full-adder chain)
   // ---------------------------------------------------------------------------
   assign carry_chain[0] = carry_reg;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign add_sum[i]         = a_word[i] ^ b_word[i] ^ carry_chain[i];
      assign carry_chain[i+1]   = (a_word[i] & b_word[i]) |
                                  (carry_chain[i] & (a_word[i] ^ b_word[i]));
   end

   assign add_cout = carry_chain[WIDTH];

   // Carry into the MSB recovered from the MSB full-adder terms.
   assign msb_carry_in = a_word[WIDTH-1] ^ b_word[WIDTH-1] ^ add_sum[WIDTH-1];

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (in_valid)   state_next = RUN;
         RUN:  if (last_slice) state_next = DONE;
         DONE: if (out_ready)  state_next = IDLE;
         default:              state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Operand registers
   // ---------------------------------------------------------------------------
   // NOTE: the operand registers carry no reset: they are only read in RUN,
   // which can only be entered through a load, so their reset value is never
   // observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= a;
         b_reg <= op_sub ? ~b : b;
      end
   end

   // ---------------------------------------------------------------------------
   // Slice index, carry and result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         if (accept) begin
            // Subtract as a + ~b + ~borrow_in.
            carry_reg <= op_sub ? ~cin : cin;
            idx       <= '0;
         end else if (state == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
               if (idx == IDX_W'(w)) sum_reg[w*WIDTH +: WIDTH] <= add_sum;
            end
            carry_reg <= add_cout;
            if (last_slice) begin
               idx      <= '0;
               cout_reg <= add_cout;
               ovf_reg  <= msb_carry_in ^ add_cout;
            end else begin
               idx <= idx + IDX_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign overflow  = ovf_reg;

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Sequences one shared WIDTH-bit ripple adder (FullAdder chain) over WORDS consecutive words.
- Produces a WORDS*WIDTH-bit add or subtract using one word slice per cycle.
- Carry is held in a register between word slices.
- Sits between a wide-operand requester and the result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, bits per word slice; the shared adder width; must be ≥2.
- WORDS, 4, number of word slices per operation; must be ≥1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active low.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE.
- op_sub  input  1  0 = a+b+cin; 1 = a−b−cin (cin acts as borrow-in).
- cin  input  1  carry-in (add) or borrow-in (sub).
- a  input  WORDS*WIDTH  operand A, two's complement, word 0 = LSBs.
- b  input  WORDS*WIDTH  operand B.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WORDS*WIDTH  result.
- cout  output  1  carry out of the MSB of the final word; for sub, 1 = no borrow.
- overflow  output  1  signed overflow of the full-width result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, word index=0, carry register=0.
  - sum=0, cout=0, overflow=0, out_valid=0, busy=0; in_ready=1 once state is IDLE.
  - Any operation in flight is abandoned; no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch a into A_reg and (op_sub ? ~b : b) into B_reg.
  - Carry register := op_sub ? ~cin : cin. Index := 0. Go to RUN.
- RUN (in_ready=0, busy=1):
  - Each cycle the shared adder takes A_reg word[idx], B_reg word[idx] and the carry register.
  - At the edge: sum word[idx] := adder sum; carry register := adder carry-out; idx++.
  - On the edge with idx==WORDS−1:
    - cout := adder carry-out.
    - overflow := carry-into-MSB XOR carry-out-of-MSB, where carry-into-MSB = A_msb ^ B_msb ^ S_msb of the final word.
    - Go to DONE.
  - Inputs a, b, op_sub and cin are ignored during RUN.
- DONE:
  - out_valid=1; sum, cout and overflow stay stable until the handshake.
  - On out_ready=1: go to IDLE, out_valid=0. sum, cout and overflow keep their last value until the next op overwrites them.
  - out_ready low holds DONE indefinitely.
- Latency and throughput:
  - Request accepted at edge t; out_valid rises after edge t+WORDS.
  - Minimum one IDLE cycle between operations: throughput of 1 op per WORDS+2 cycles.
- WORDS=1: RUN lasts exactly one cycle; behaviour is otherwise identical.
- Earlier sum words are stable once written; the next op overwrites sum word by word during RUN.
- out_valid and in_ready are never high simultaneously.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE and is not queued.

Test Plan (WIDTH=8, WORDS=4):
- Add 0x000000FF + 0x00000001, op_sub=0, cin=0 -> sum=0x00000100, cout=0, overflow=0. out_valid rises 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, overflow=1.
- Add 0xFFFFFFFF + 0x00000000 with cin=1 -> sum=0x00000000, cout=1, overflow=0.
- Subtract 0x00000000 − 0x00000001, cin=0 -> sum=0xFFFFFFFF, cout=0 (borrow), overflow=0. Subtract 0x80000000 − 0x00000001 -> sum=0x7FFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stable; in_ready=0 throughout; a new in_valid is not accepted until one edge after out_ready=1.
- Reset mid-RUN (rst_n low at word index 2) -> immediately out_valid=0, busy=0, sum=0. After release, in_ready=1, and the next op 0x00000001+0x00000001 yields sum=0x00000002.
